bist_response_analyzer: RTL

- Response-side counterpart to the ALU BIST pattern controller: it accepts the stream of ALU responses and compacts them into an 8-bit MISR signature.
- At the end of the stream it compares the signature against a golden value and reports pass or fail.
- Sits between the ALU result bus and the BIST status outputs.
- A watchdog flags a stalled stream.

---
 rtl/bist_response_analyzer_if.sv | 25 ++
 rtl/bist_response_analyzer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/bist_response_analyzer_if.sv
// Response stream between the ALU result bus and the BIST response analyzer.
// The master drives each beat; the slave (analyzer) drives resp_ready.
interface bist_response_analyzer_if #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 3
);
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic [OP_W-1:0]   resp_opcode;

    modport master (
        output resp_valid,
        output resp_data,
        output resp_opcode,
        input  resp_ready
    );

    modport slave (
        input  resp_valid,
        input  resp_data,
        input  resp_opcode,
        output resp_ready
    );
endinterface

// File: rtl/bist_response_analyzer.sv
// BIST response analyzer: compacts ALU responses into an MISR signature,
// compares against a golden value and reports pass/fail, with a stall watchdog.
module bist_response_analyzer #(
    parameter int                 DATA_W      = 8,
    parameter int                 OP_W        = 3,
    parameter int                 NUM_VECTORS = 5,
    parameter logic [DATA_W-1:0]  MISR_POLY   = 8'h1D,
    parameter logic [DATA_W-1:0]  MISR_SEED   = 8'hFF,
    parameter int                 TIMEOUT     = 16,
    localparam int                CNT_W       = $clog2(NUM_VECTORS + 1)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [DATA_W-1:0]         golden_sig,
    bist_response_analyzer_if.slave   resp,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic                      fail,
    output logic                      timeout,
    output logic [DATA_W-1:0]         signature,
    output logic [CNT_W-1:0]          resp_count
);

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_COMPARE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t              state_r,      state_nxt_s;
    logic [DATA_W-1:0]   sig_r,        sig_nxt_s;
    logic [CNT_W-1:0]    count_r,      count_nxt_s;
    logic [WD_W-1:0]     wd_r,         wd_nxt_s;
    logic                ready_r,      ready_nxt_s;
    logic                busy_r,       busy_nxt_s;
    logic                done_r,       done_nxt_s;
    logic                pass_r,       pass_nxt_s;
    logic                fail_r,       fail_nxt_s;
    logic                timeout_r,    timeout_nxt_s;

    logic                accept_s;
    logic                last_beat_s;
    logic                all_in_s;
    logic                wd_expire_s;

    // One MISR step: shift, conditional polynomial feedback, fold in data^opcode.
    function automatic logic [DATA_W-1:0] misr_step(
        input logic [DATA_W-1:0] sig,
        input logic [DATA_W-1:0] data,
        input logic [OP_W-1:0]   op
    );
        logic [DATA_W-1:0] fold;
        logic [DATA_W-1:0] fb;
        fold = data ^ {{(DATA_W-OP_W){1'b0}}, op};
        fb   = sig[DATA_W-1] ? MISR_POLY : {DATA_W{1'b0}};
        return {sig[DATA_W-2:0], 1'b0} ^ fb ^ fold;
    endfunction

    assign accept_s    = resp.resp_valid && ready_r && (state_r == ST_COLLECT);
    assign last_beat_s = accept_s && (count_r == CNT_W'(NUM_VECTORS - 1));
    assign all_in_s    = (count_r == CNT_W'(NUM_VECTORS));
    // An accept always wins over expiry, and expiry is moot once every beat is in.
    assign wd_expire_s = (TIMEOUT != 0) && !accept_s && !all_in_s &&
                         (wd_r == WD_W'(TIMEOUT - 1));

    // Next-state and next-output decode for the analyzer FSM.
    always_comb begin
        state_nxt_s   = state_r;
        sig_nxt_s     = sig_r;
        count_nxt_s   = count_r;
        wd_nxt_s      = wd_r;
        ready_nxt_s   = ready_r;
        busy_nxt_s    = busy_r;
        done_nxt_s    = done_r;
        pass_nxt_s    = pass_r;
        fail_nxt_s    = fail_r;
        timeout_nxt_s = timeout_r;

        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt_s   = ST_COLLECT;
                    sig_nxt_s     = MISR_SEED;
                    count_nxt_s   = {CNT_W{1'b0}};
                    wd_nxt_s      = {WD_W{1'b0}};
                    ready_nxt_s   = 1'b1;
                    busy_nxt_s    = 1'b1;
                    done_nxt_s    = 1'b0;
                    pass_nxt_s    = 1'b0;
                    fail_nxt_s    = 1'b0;
                    timeout_nxt_s = 1'b0;
                end else begin
                    state_nxt_s   = state_r;
                end
            end

            ST_COLLECT: begin
                if (accept_s) begin
                    sig_nxt_s   = misr_step(sig_r, resp.resp_data, resp.resp_opcode);
                    count_nxt_s = count_r + CNT_W'(1'b1);
                    wd_nxt_s    = {WD_W{1'b0}};
                    ready_nxt_s = !last_beat_s;
                end else if (all_in_s) begin
                    // One settling cycle after the final beat keeps done at two edges out.
                    state_nxt_s = ST_COMPARE;
                end else if (wd_expire_s) begin
                    state_nxt_s   = ST_DONE;
                    ready_nxt_s   = 1'b0;
                    busy_nxt_s    = 1'b0;
                    done_nxt_s    = 1'b1;
                    pass_nxt_s    = 1'b0;
                    fail_nxt_s    = 1'b1;
                    timeout_nxt_s = 1'b1;
                end else begin
                    wd_nxt_s = wd_r + WD_W'(1'b1);
                end
            end

            ST_COMPARE: begin
                state_nxt_s   = ST_DONE;
                ready_nxt_s   = 1'b0;
                busy_nxt_s    = 1'b0;
                done_nxt_s    = 1'b1;
                pass_nxt_s    = (sig_r == golden_sig);
                fail_nxt_s    = (sig_r != golden_sig);
                timeout_nxt_s = 1'b0;
            end

            default: begin
                state_nxt_s   = ST_IDLE;
                ready_nxt_s   = 1'b0;
                busy_nxt_s    = 1'b0;
                done_nxt_s    = 1'b0;
                pass_nxt_s    = 1'b0;
                fail_nxt_s    = 1'b0;
                timeout_nxt_s = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any run in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            sig_r     <= MISR_SEED;
            count_r   <= {CNT_W{1'b0}};
            wd_r      <= {WD_W{1'b0}};
            ready_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            pass_r    <= 1'b0;
            fail_r    <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            sig_r     <= sig_nxt_s;
            count_r   <= count_nxt_s;
            wd_r      <= wd_nxt_s;
            ready_r   <= ready_nxt_s;
            busy_r    <= busy_nxt_s;
            done_r    <= done_nxt_s;
            pass_r    <= pass_nxt_s;
            fail_r    <= fail_nxt_s;
            timeout_r <= timeout_nxt_s;
        end
    end

    assign resp.resp_ready = ready_r;
    assign busy            = busy_r;
    assign done            = done_r;
    assign pass            = pass_r;
    assign fail            = fail_r;
    assign timeout         = timeout_r;
    assign signature       = sig_r;
    assign resp_count      = count_r;

endmodule
